bcd_count_latch: RTL and testbench

BCD_COUNT_LATCH -- requirements
Module: bcd_count_latch

---
 rtl/bcd_count_latch.sv | 117 +++++++++++
 tb/tb_bcd_count_latch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_latch.sv
// bcd_count_latch: NDIG-digit BCD counter with terminal-count pulse and ld-edge result latch.
// Latency: count, enb_3, dout, valid and ovr are all registered, updating one ck after the causing edge.
// Backpressure: none; OVERRANGE_EN adds second-wrap detection with count saturation and a latched ovr.
module bcd_count_latch #(
    parameter int NDIG = 3
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              enb_0,
    input  logic              rst_s,
    input  logic              ld,
    output logic              enb_3,
    output logic [4*NDIG-1:0] count,
    output logic [4*NDIG-1:0] dout,
    output logic              valid,
    output logic              ovr
);
    localparam int W = 4 * NDIG;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] dout_q;
    logic         enb_3_q;
    logic         valid_q;
    logic         ld_d_q;
    logic         all9;
    logic         carry;
    logic         ld_rise;

`ifdef OVERRANGE_EN
    logic wrap_q;
    logic ovf_q;
    logic ovr_q;
`endif

    // Ripple BCD increment; a carry out of the top digit means the count was all-9s.
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all9 = carry;
    end

    assign ld_rise = ld && !ld_d_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
            enb_3_q <= 1'b0;
            valid_q <= 1'b0;
            ld_d_q  <= 1'b0;
`ifdef OVERRANGE_EN
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
`endif
        end else begin
            ld_d_q  <= ld;
            valid_q <= ld_rise;
            enb_3_q <= 1'b0;
            if (ld_rise) begin
                dout_q <= count_q;
`ifdef OVERRANGE_EN
                ovr_q  <= ovf_q;
`endif
            end
            if (rst_s) begin
                count_q <= '0;
`ifdef OVERRANGE_EN
                wrap_q  <= 1'b0;
                ovf_q   <= 1'b0;
`endif
            end else if (enb_0) begin
`ifdef OVERRANGE_EN
                // The second wrap still ends the interval, but the count pins at all-9s.
                if (!ovf_q) begin
                    if (all9) begin
                        enb_3_q <= 1'b1;
                        if (wrap_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_d;
                            wrap_q  <= 1'b1;
                        end
                    end else begin
                        count_q <= count_d;
                    end
                end
`else
                count_q <= count_d;
                enb_3_q <= all9;
`endif
            end
        end
    end

    assign count = count_q;
    assign dout  = dout_q;
    assign enb_3 = enb_3_q;
    assign valid = valid_q;
`ifdef OVERRANGE_EN
    assign ovr   = ovr_q;
`else
    assign ovr   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_count_latch.sv
// Bench for bcd_count_latch: integer-valued reference model compared every cycle, plus directed literal checks.
module tb_bcd_count_latch;
    localparam int NDIG = 3;
    localparam int W    = 4 * NDIG;
    localparam int MAX  = 10 ** NDIG;
`ifdef OVERRANGE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic         ck    = 1'b0;
    logic         rst_n = 1'b0;
    logic         enb_0 = 1'b0;
    logic         rst_s = 1'b0;
    logic         ld    = 1'b0;
    logic         enb_3;
    logic [W-1:0] count;
    logic [W-1:0] dout;
    logic         valid;
    logic         ovr;

    always #5 ck = ~ck;

    bcd_count_latch #(.NDIG(NDIG)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .enb_0 (enb_0),
        .rst_s (rst_s),
        .ld    (ld),
        .enb_3 (enb_3),
        .count (count),
        .dout  (dout),
        .valid (valid),
        .ovr   (ovr)
    );

    int checks = 0;
    int errors = 0;
    int n_enb3 = 0;
    int n_valid = 0;
    bit chk_on = 1'b0;

    // Reference model: the count is a plain integer in 0..MAX-1.
    int m_cnt = 0;
    int m_dout = 0;
    bit m_wrapped = 1'b0;
    bit m_ovf = 1'b0;
    bit m_enb3 = 1'b0;
    bit m_valid = 1'b0;
    bit m_ovr = 1'b0;
    bit m_ld_prev = 1'b0;

    function automatic logic [W-1:0] bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_dout = 0; m_wrapped = 0; m_ovf = 0;
            m_enb3 = 0; m_valid = 0; m_ovr = 0; m_ld_prev = 0;
        end else begin
            m_enb3  = 1'b0;
            m_valid = 1'b0;
            if (ld && !m_ld_prev) begin
                m_dout  = m_cnt;
                m_ovr   = m_ovf;
                m_valid = 1'b1;
            end
            m_ld_prev = ld;
            if (rst_s) begin
                m_cnt = 0; m_wrapped = 0; m_ovf = 0;
            end else if (enb_0) begin
                if (OVR && m_ovf) begin
                    m_cnt = m_cnt;
                end else if (m_cnt == MAX - 1) begin
                    m_enb3 = 1'b1;
                    if (OVR && m_wrapped) m_ovf = 1'b1;
                    else begin
                        m_cnt = 0;
                        m_wrapped = 1'b1;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    always @(negedge ck) begin
        if (chk_on) begin
            chk("count", 32'(count), 32'(bcd(m_cnt)));
            chk("dout", 32'(dout), 32'(bcd(m_dout)));
            chk("enb_3", 32'(enb_3), 32'(m_enb3));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("ovr", 32'(ovr), 32'(m_ovr));
            if (enb_3 === 1'b1) n_enb3++;
            if (valid === 1'b1) n_valid++;
        end
    end

    task automatic cyc(input bit e, input bit r, input bit l);
        enb_0 = e;
        rst_s = r;
        ld    = l;
        @(negedge ck);
    endtask

    task automatic incs(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int pv;
        bit nl;
        rst_n = 1'b0;
        @(negedge ck);
        chk_on = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, i[0]);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);

        ld = 1'b0;
        rst_n = 1'b1;
        incs(5);
        chk("cnt5", 32'(count), 32'h005);
        cyc(1'b0, 1'b0, 1'b0);
        chk("no_enb3_after_5", 32'(n_enb3), 32'd0);

        cyc(1'b0, 1'b1, 1'b0);
        p = n_enb3;
        incs(999);
        chk("cnt999", 32'(count), 32'h999);
        incs(1);
        chk("wrap_cnt", 32'(count), 32'h000);
        chk("wrap_enb3", 32'(enb_3), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wrap_enb3_low", 32'(enb_3), 32'd0);
        chk("wrap_pulses", 32'(n_enb3 - p), 32'd1);

        cyc(1'b0, 1'b1, 1'b0);
        incs(123);
        pv = n_valid;
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ld_dout", 32'(dout), 32'h123);
        chk("ld_one_valid", 32'(n_valid - pv), 32'd1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("ld_inc_dout", 32'(dout), 32'h123);
        chk("ld_inc_cnt", 32'(count), 32'h124);
        cyc(1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        incs(999);
        p = n_enb3;
        cyc(1'b1, 1'b1, 1'b0);
        chk("clr_over_inc", 32'(count), 32'h000);
        cyc(1'b0, 1'b0, 1'b0);
        chk("clr_no_enb3", 32'(n_enb3 - p), 32'd0);

        incs(456);
        cyc(1'b0, 1'b1, 1'b1);
        chk("clr_ld_dout", 32'(dout), 32'h456);
        chk("clr_ld_cnt", 32'(count), 32'h000);
        cyc(1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        p = n_enb3;
        incs(2100);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("run2100_pulses", 32'(n_enb3 - p), 32'd2);
`ifdef OVERRANGE_EN
        chk("ovr_cnt_sat", 32'(count), 32'h999);
        chk("ovr_dout", 32'(dout), 32'h999);
        chk("ovr_set", 32'(ovr), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        incs(10);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ovr_re_dout", 32'(dout), 32'h010);
        chk("ovr_cleared", 32'(ovr), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
`else
        chk("nov_cnt", 32'(count), 32'h100);
        chk("nov_ovr", 32'(ovr), 32'd0);
`endif

        cyc(1'b0, 1'b1, 1'b0);
        incs(999);
        enb_0 = 1'b1;
        @(posedge ck);
        #1 rst_n = 1'b0;
        enb_0 = 1'b0;
        @(negedge ck);
        chk("abort_enb3", 32'(enb_3), 32'd0);
        chk("abort_cnt", 32'(count), 32'h000);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        chk("rel_ld_valid", 32'(valid), 32'd1);
        chk("rel_ld_enb3", 32'(enb_3), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            nl = ($urandom_range(0, 15) == 0) ? ~ld : ld;
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1999) == 0, nl);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
